// File: rtl/uart_rx_deframer.sv
// UART receive deframer: RX pin synchroniser, DLR-driven 16x oversample timing, start/data/parity/stop
// deframing with a valid/ready holding register. Optional build macro: RX_MAJORITY_VOTE_EN.
`timescale 1ns/1ps
module uart_rx_deframer #(
  parameter int OSR     = 16,
  parameter int SYNC_FF = 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        RX,
  input  logic [15:0] DLR,
  input  logic [7:0]  LCR,
  output logic [7:0]  rx_data,
  output logic        rx_pe,
  output logic        rx_fe,
  output logic        rx_bi,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_oe,
  output logic        rx_busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_WAIT_IDLE
  } state_t;

  localparam int CW = $clog2(OSR);
  localparam logic [CW-1:0] LAST_C = CW'(OSR - 1);
`ifdef RX_MAJORITY_VOTE_EN
  // The vote needs the third sample, so the bit value resolves one tick after mid-bit.
  localparam logic [CW-1:0] SAMP_C = CW'(OSR / 2);
  localparam logic [CW-1:0] V0_C   = CW'(OSR / 2 - 2);
  localparam logic [CW-1:0] V1_C   = CW'(OSR / 2 - 1);
`else
  localparam logic [CW-1:0] SAMP_C = CW'(OSR / 2 - 1);
`endif

  function automatic logic exp_parity(input logic [7:0] d, input logic eps, input logic stick);
    logic p;
    if (stick) p = ~eps;
    else if (eps) p = ^d;
    else p = ~(^d);
    return p;
  endfunction

  logic [SYNC_FF-1:0] sync_r;
  logic               rx_s;
  logic [15:0]        div_r;
  logic               tick_s;
  logic               bit_s;
  state_t             state_r;
  logic [CW-1:0]      os_cnt_r;
  logic [2:0]         bit_cnt_r;
  logic [7:0]         shift_r;
  logic [1:0]         wlen_r;
  logic               pen_r, eps_r, stick_r, par_bit_r;
  logic [7:0]         rx_data_r;
  logic               rx_pe_r, rx_fe_r, rx_bi_r, rx_valid_r, rx_oe_r;
  logic               unused_lcr_s;

  assign unused_lcr_s = ^{LCR[7:6], LCR[2]};
  assign rx_s         = sync_r[SYNC_FF-1];
  assign tick_s       = (DLR != 16'd0) && (div_r == 16'd0);

  // RX pin synchroniser, idles high.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_r <= {SYNC_FF{1'b1}};
    end else begin
      sync_r[0] <= RX;
      for (int i = 1; i < SYNC_FF; i++) sync_r[i] <= sync_r[i-1];
    end
  end

  // Oversample tick divider; a new DLR is picked up only at reload.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) div_r <= 16'd0;
    else if (DLR == 16'd0) div_r <= 16'd0;
    else if (div_r == 16'd0) div_r <= DLR - 16'd1;
    else div_r <= div_r - 16'd1;
  end

`ifdef RX_MAJORITY_VOTE_EN
  logic [1:0] vote_r;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Capture the two samples that precede the resolving tick.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) vote_r <= 2'b11;
    else if (tick_s && os_cnt_r == V0_C) vote_r[0] <= rx_s;
    else if (tick_s && os_cnt_r == V1_C) vote_r[1] <= rx_s;
    else vote_r <= vote_r;
  end

  assign bit_s = maj3(vote_r[0], vote_r[1], rx_s);
`else
  assign bit_s = rx_s;
`endif

  // Deframing FSM together with the output holding register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_r    <= ST_IDLE;
      os_cnt_r   <= {CW{1'b0}};
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'd0;
      wlen_r     <= 2'd0;
      pen_r      <= 1'b0;
      eps_r      <= 1'b0;
      stick_r    <= 1'b0;
      par_bit_r  <= 1'b0;
      rx_data_r  <= 8'd0;
      rx_pe_r    <= 1'b0;
      rx_fe_r    <= 1'b0;
      rx_bi_r    <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_oe_r    <= 1'b0;
    end else begin
      rx_oe_r <= 1'b0;
      if (rx_valid_r && rx_ready) rx_valid_r <= 1'b0;
      if (DLR == 16'd0) begin
        state_r   <= ST_IDLE;
        os_cnt_r  <= {CW{1'b0}};
        bit_cnt_r <= 3'd0;
      end else if (tick_s) begin
        os_cnt_r <= os_cnt_r + CW'(1);
        case (state_r)
          ST_IDLE: begin
            os_cnt_r <= {CW{1'b0}};
            if (!rx_s) state_r <= ST_START;
          end
          ST_START: begin
            if (os_cnt_r == SAMP_C) begin
              if (bit_s) begin
                state_r <= ST_IDLE;
              end else begin
                wlen_r    <= LCR[1:0];
                pen_r     <= LCR[3];
                eps_r     <= LCR[4];
                stick_r   <= LCR[5];
                shift_r   <= 8'd0;
                bit_cnt_r <= 3'd0;
              end
            end else if (os_cnt_r == LAST_C) begin
              state_r <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (os_cnt_r == SAMP_C) shift_r[bit_cnt_r] <= bit_s;
            if (os_cnt_r == LAST_C) begin
              if (bit_cnt_r == 3'd4 + {1'b0, wlen_r}) begin
                bit_cnt_r <= 3'd0;
                state_r   <= pen_r ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
              end
            end
          end
          ST_PARITY: begin
            if (os_cnt_r == SAMP_C) par_bit_r <= bit_s;
            if (os_cnt_r == LAST_C) state_r <= ST_STOP;
          end
          ST_STOP: begin
            // Frame completes at the stop sample, not at the end of the stop bit.
            if (os_cnt_r == SAMP_C) begin
              state_r <= bit_s ? ST_IDLE : ST_WAIT_IDLE;
              if (!rx_valid_r || rx_ready) begin
                rx_data_r  <= shift_r;
                rx_pe_r    <= pen_r & (par_bit_r ^ exp_parity(shift_r, eps_r, stick_r));
                rx_fe_r    <= ~bit_s;
                rx_bi_r    <= (shift_r == 8'd0) & (~pen_r | ~par_bit_r) & ~bit_s;
                rx_valid_r <= 1'b1;
              end else begin
                rx_oe_r <= 1'b1;
              end
            end
          end
          ST_WAIT_IDLE: begin
            if (rx_s) state_r <= ST_IDLE;
          end
          default: state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data  = rx_data_r;
  assign rx_pe    = rx_pe_r;
  assign rx_fe    = rx_fe_r;
  assign rx_bi    = rx_bi_r;
  assign rx_valid = rx_valid_r;
  assign rx_oe    = rx_oe_r;
  assign rx_busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: drives serial frames at DLR=13 / OSR=16 (208 PCLK per bit)
// and compares received characters against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  localparam int BIT = 208;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } chr_t;

  logic        PCLK, PRESET, RX, rx_ready;
  logic [15:0] DLR;
  logic [7:0]  LCR;
  logic [7:0]  rx_data;
  logic        rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy;

  int   checks = 0;
  int   failures = 0;
  int   oe_cnt = 0;
  chr_t got_q[$];
  chr_t exp_q[$];

  uart_rx_deframer #(.OSR(16), .SYNC_FF(2)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .RX(RX), .DLR(DLR), .LCR(LCR),
    .rx_data(rx_data), .rx_pe(rx_pe), .rx_fe(rx_fe), .rx_bi(rx_bi),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_oe(rx_oe), .rx_busy(rx_busy)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Collect every accepted character and every overrun pulse.
  always @(negedge PCLK) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_data, rx_pe, rx_fe, rx_bi});
    if (rx_oe) oe_cnt++;
  end

  // Reference: what a receiver must report for a frame, from the line-control rules.
  function automatic chr_t model(input logic [7:0] d, input logic [7:0] lcr, input logic par, input logic stop);
    chr_t c;
    int n, ones;
    logic even_bit, want;
    n = 5 + int'(lcr[1:0]);
    c.d = 8'(int'(d) % (1 << n));
    ones = $countones(c.d);
    even_bit = (ones % 2) == 1;
    if (lcr[5]) want = !lcr[4];
    else if (lcr[4]) want = even_bit;
    else want = !even_bit;
    c.pe = lcr[3] && (par != want);
    c.fe = !stop;
    c.bi = (c.d == 8'd0) && (!lcr[3] || !par) && !stop;
    return c;
  endfunction

  task automatic send_bit(input logic b);
    RX = b;
    repeat (BIT) @(negedge PCLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [7:0] lcr, input logic [7:0] lcr_mid,
                            input logic par, input logic stop, input int idle_bits);
    LCR = lcr;
    send_bit(1'b0);
    LCR = lcr_mid;
    for (int i = 0; i < 5 + int'(lcr[1:0]); i++) send_bit(d[i]);
    if (lcr[3]) send_bit(par);
    send_bit(stop);
    for (int i = 0; i < idle_bits; i++) send_bit(1'b1);
  endtask

  task automatic test_reset;
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    checks++;
    if ({rx_data, rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {rx_data, rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy});
    end
    PRESET = 1'b0;
    repeat (20) @(negedge PCLK);
  endtask

  task automatic test_8n1;
    rx_ready = 1'b0;
    send_frame(8'h45, 8'h03, 8'h03, 1'b0, 1'b1, 1);
    checks++;
    if ({rx_valid, rx_data, rx_pe, rx_fe, rx_bi} !== {1'b1, 8'h45, 3'b000}) begin
      failures++;
      $display("FAIL 8n1_char got=%h exp=%h", {rx_valid, rx_data, rx_pe, rx_fe, rx_bi}, {1'b1, 8'h45, 3'b000});
    end
    rx_ready = 1'b1;
    @(negedge PCLK);
    checks++;
    if (rx_valid !== 1'b0) begin
      failures++;
      $display("FAIL 8n1_handshake_clear got=%b exp=0", rx_valid);
    end
    got_q.delete();
  endtask

  task automatic test_parity;
    exp_q.delete();
    send_frame(8'hA5, 8'h1B, 8'h1B, 1'b1, 1'b1, 2);
    exp_q.push_back(model(8'hA5, 8'h1B, 1'b1, 1'b1));
    send_frame(8'hA5, 8'h1B, 8'h1B, 1'b0, 1'b1, 2);
    exp_q.push_back(model(8'hA5, 8'h1B, 1'b0, 1'b1));
    checks++;
    if (got_q.size() != 2 || got_q[0] !== {8'hA5, 3'b100} || got_q[1] !== {8'hA5, 3'b000}) begin
      failures++;
      $display("FAIL parity_even n=%0d got0=%h exp0=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, {8'hA5, 3'b100});
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL parity_model%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
  endtask

  task automatic test_framing_hold;
    exp_q.delete();
    send_frame(8'h15, 8'h00, 8'h00, 1'b0, 1'b0, 0);
    exp_q.push_back(model(8'h15, 8'h00, 1'b0, 1'b0));
    repeat (30) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_frame(8'h0A, 8'h00, 8'h00, 1'b0, 1'b1, 2);
    exp_q.push_back(model(8'h0A, 8'h00, 1'b0, 1'b1));
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL framing_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL framing_char%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
  endtask

  task automatic test_break;
    LCR = 8'h0B;
    repeat (12) send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL break_count got=%0d exp=1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {8'h00, 3'b111} || got_q[0] !== model(8'h00, 8'h0B, 1'b0, 1'b0)) begin
        failures++;
        $display("FAIL break_char got=%h exp=%h", got_q[0], {8'h00, 3'b111});
      end
    end
    got_q.delete();
  endtask

  task automatic test_glitch;
    logic seen_busy;
    RX = 1'b0;
    repeat (40) @(negedge PCLK);
    seen_busy = rx_busy;
    repeat (25) @(negedge PCLK);
    RX = 1'b1;
    repeat (20 * 13) @(negedge PCLK);
    checks++;
    if (seen_busy !== 1'b1 || rx_busy !== 1'b0 || got_q.size() != 0) begin
      failures++;
      $display("FAIL glitch got busy_mid=%b busy_end=%b chars=%0d exp 1 0 0", seen_busy, rx_busy, got_q.size());
    end
    got_q.delete();
  endtask

  task automatic test_lcr_latch;
    send_frame(8'hC3, 8'h03, 8'h08, 1'b0, 1'b1, 2);
    LCR = 8'h03;
    checks++;
    if (got_q.size() != 1 || got_q[0] !== model(8'hC3, 8'h03, 1'b0, 1'b1)) begin
      failures++;
      $display("FAIL lcr_latch n=%0d got=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, model(8'hC3, 8'h03, 1'b0, 1'b1));
    end
    got_q.delete();
  endtask

  task automatic test_random;
    logic [7:0] d, lcr;
    logic par, stop;
    exp_q.delete();
    oe_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom);
      lcr  = 8'($urandom) & 8'h3F;
      par  = 1'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(d, lcr, lcr, par, stop, 2);
      exp_q.push_back(model(d, lcr, par, stop));
    end
    checks++;
    if (got_q.size() != exp_q.size() || oe_cnt != 0) begin
      failures++;
      $display("FAIL random_count got=%0d exp=%0d oe=%0d", got_q.size(), exp_q.size(), oe_cnt);
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_char%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete();
  endtask

  task automatic test_overrun;
    rx_ready = 1'b0;
    oe_cnt = 0;
    send_frame(8'h11, 8'h03, 8'h03, 1'b0, 1'b1, 1);
    send_frame(8'h22, 8'h03, 8'h03, 1'b0, 1'b1, 1);
    checks++;
    if (oe_cnt != 1) begin
      failures++;
      $display("FAIL overrun_pulses got=%0d exp=1", oe_cnt);
    end
    checks++;
    if ({rx_valid, rx_data, rx_pe, rx_fe, rx_bi} !== {1'b1, 8'h11, 3'b000}) begin
      failures++;
      $display("FAIL overrun_held got=%h exp=%h", {rx_valid, rx_data, rx_pe, rx_fe, rx_bi}, {1'b1, 8'h11, 3'b000});
    end
  endtask

  task automatic test_reset_mid_frame;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    RX = 1'b1;
    repeat (BIT / 2) @(negedge PCLK);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL midframe_busy got=%b exp=1", rx_busy);
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({rx_data, rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy} !== 14'd0) begin
      failures++;
      $display("FAIL midframe_reset got=%h exp=0", {rx_data, rx_pe, rx_fe, rx_bi, rx_valid, rx_oe, rx_busy});
    end
    PRESET = 1'b0;
    repeat (3 * BIT) @(negedge PCLK);
    rx_ready = 1'b1;
    got_q.delete();
    send_frame(8'h5A, 8'h03, 8'h03, 1'b0, 1'b1, 2);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h5A, 3'b000}) begin
      failures++;
      $display("FAIL after_reset n=%0d got=%h exp=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 11'h0, {8'h5A, 3'b000});
    end
    got_q.delete();
  endtask

  task automatic test_dlr_zero;
    DLR = 16'd0;
    send_frame(8'h33, 8'h03, 8'h03, 1'b0, 1'b1, 2);
    checks++;
    if (got_q.size() != 0 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL dlr_zero chars=%0d busy=%b exp 0 0", got_q.size(), rx_busy);
    end
    DLR = 16'd13;
    send_bit(1'b1);
  endtask

  initial begin
    PRESET = 1'b1;
    RX = 1'b1;
    DLR = 16'd13;
    LCR = 8'h03;
    rx_ready = 1'b1;
    test_reset();
    test_8n1();
    test_parity();
    test_framing_hold();
    test_break();
    test_glitch();
    test_lcr_latch();
    test_random();
    test_overrun();
    test_reset_mid_frame();
    test_dlr_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
